muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per clock, with signed/unsigned variants and a divide-by-zero flag.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            dz_pend;

  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] p_hi, p_lo;
  logic             neg_q, neg_r;

  function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v,
                                               input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] sign_fix2(input logic [2*WIDTH-1:0] v,
                                                   input logic neg);
    return neg ? -v : v;
  endfunction

  logic               accept;
  logic               is_div, is_signed, a_neg, b_neg;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_fit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept    = start && (state == IDLE || state == DONE);
  assign is_div    = op_r[1];
  assign is_signed = ~op_r[0];
  assign a_neg     = is_signed & a_r[WIDTH-1];
  assign b_neg     = is_signed & b_r[WIDTH-1];

  // Multiply keeps the multiplier in p_lo and shifts the partial product down through it.
  assign mul_sum   = {1'b0, p_hi} + {1'b0, (p_lo[0] ? mag_a : '0)};

  // Divide shifts the dividend out of p_lo into the remainder; quotient bits fill p_lo.
  assign div_shift = {p_hi, p_lo[WIDTH-1]};
  assign div_fit   = div_shift >= {1'b0, mag_b};
  assign div_rem   = div_fit ? (div_shift[WIDTH-1:0] - mag_b) : div_shift[WIDTH-1:0];

  assign prod_fix  = sign_fix2({p_hi, p_lo}, neg_q);

  // Operand capture and iteration datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r <= op;
      a_r  <= a;
      b_r  <= b;
    end else if (state == PREP) begin
      mag_a <= abs_val(a_r, is_signed);
      mag_b <= abs_val(b_r, is_signed);
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      p_hi  <= '0;
      p_lo  <= is_div ? abs_val(a_r, is_signed) : abs_val(b_r, is_signed);
    end else if (state == CALC) begin
      if (is_div) begin
        p_hi <= div_rem;
        p_lo <= {p_lo[WIDTH-2:0], div_fit};
      end else begin
        p_hi <= mul_sum[WIDTH:1];
        p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      ready    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      dz_pend  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= PREP;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        PREP: begin
          // A zero divisor holds PREP for a second cycle so ready lands two edges after start.
          if (is_div && b_r == '0) begin
            div_zero <= 1'b1;
            if (dz_pend) begin
              dz_pend <= 1'b0;
              state   <= DONE;
              ready   <= 1'b1;
            end else begin
              dz_pend <= 1'b1;
            end
          end else begin
            div_zero <= 1'b0;
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          hi    <= is_div ? sign_fix(p_hi, neg_r) : prod_fix[2*WIDTH-1:WIDTH];
          lo    <= is_div ? sign_fix(p_lo, neg_q) : prod_fix[WIDTH-1:0];
          state <= DONE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
